// File: rtl/set_dispatch.sv
// set_dispatch: 4-deep command FIFO feeding a set-counting engine, one command in flight.
// Optional engine watchdog is compiled in when SET_DISP_TIMEOUT_EN is defined.
module set_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_central,
    input  logic [11:0] cmd_radius,
    input  logic [1:0]  cmd_mode,
    output logic        set_en,
    output logic [23:0] set_central,
    output logic [11:0] set_radius,
    output logic [1:0]  set_mode,
    input  logic        set_busy,
    input  logic        set_valid,
    input  logic [7:0]  set_candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic [1:0]  res_mode,
    output logic        err
);

    localparam int unsigned Depth  = 4;
    localparam int unsigned EntryW = 38;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0] mem_q [Depth];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;
    logic [EntryW-1:0] head;

    logic push, pop, capture, timeout, release_res, tmo_hit;

    // Engine status is informational only; completion is signalled by set_valid.
    logic unused_busy;
    assign unused_busy = set_busy;

    assign cmd_ready = rst & (count_q != 3'd4);
    assign push      = cmd_valid & cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign set_en    = (state_q == StIssue);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_mode, cmd_radius, cmd_central};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;
        release_res = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != 3'd0) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (set_valid) begin
                    capture = 1'b1;
                    state_d = StOut;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // set_* stay loaded from pop until the next pop, so they are stable through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            set_central   <= '0;
            set_radius    <= '0;
            set_mode      <= '0;
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_mode      <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                {set_mode, set_radius, set_central} <= head;
            end
            if (capture) begin
                res_valid     <= 1'b1;
                res_candidate <= set_candidate;
                res_mode      <= set_mode;
            end else if (timeout) begin
                res_valid     <= 1'b1;
                res_candidate <= 8'hFF;
                res_mode      <= set_mode;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SET_DISP_TIMEOUT_EN
    localparam logic [6:0] TimeoutLast = 7'd79;

    logic [6:0] tmo_q;
    logic       err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                tmo_q <= '0;
            end else if (state_q == StWait) begin
                tmo_q <= tmo_q + 7'd1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    // Fires on the edge where the counter would reach 80.
    assign tmo_hit = (state_q == StWait) && (tmo_q == TimeoutLast);
    assign err     = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_set_dispatch.sv
// Directed testbench for set_dispatch with a behavioral set-counting engine model.
// Build with +define+SET_DISP_TIMEOUT_EN to exercise the watchdog path.
module tb_set_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [23:0] cmd_central;
    logic [11:0] cmd_radius;
    logic [1:0]  cmd_mode;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy, set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid, res_ready;
    logic [7:0]  res_candidate;
    logic [1:0]  res_mode;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
        logic [7:0]  exp_cand;
    } vec_t;

    vec_t vecs [5];
    vec_t bp   [5];

    set_dispatch dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_central  (cmd_central),
        .cmd_radius   (cmd_radius),
        .cmd_mode     (cmd_mode),
        .set_en       (set_en),
        .set_central  (set_central),
        .set_radius   (set_radius),
        .set_mode     (set_mode),
        .set_busy     (set_busy),
        .set_valid    (set_valid),
        .set_candidate(set_candidate),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_candidate(res_candidate),
        .res_mode     (res_mode),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: counts lattice points dx,dy in -2..2 within radius[3:0];
    // set_valid is sampled by the DUT 65 edges after the set_en edge.
    logic eng_busy, eng_stall, spur;
    int   eng_cnt;

    function automatic logic [7:0] count_pts(input logic [3:0] r);
        int n = 0;
        for (int dx = -2; dx <= 2; dx++)
            for (int dy = -2; dy <= 2; dy++)
                if (dx * dx + dy * dy <= int'(r) * int'(r)) n++;
        return n[7:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_busy      <= 1'b0;
            eng_cnt       <= 0;
            set_valid     <= 1'b0;
            set_candidate <= '0;
        end else begin
            set_valid <= spur;
            if (spur) set_candidate <= 8'h5A;
            if (set_en) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 1;
            end else if (eng_busy) begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt == 64 && !eng_stall) begin
                    set_valid     <= 1'b1;
                    set_candidate <= count_pts(set_radius[3:0]);
                    eng_busy      <= 1'b0;
                end
            end
        end
    end
    assign set_busy = eng_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cmd(input vec_t v, output int at);
        cmd_valid   = 1'b1;
        cmd_central = v.central;
        cmd_radius  = v.radius;
        cmd_mode    = v.mode;
        at          = cyc;
        check("push_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_set_en(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (set_en) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_res(input int limit, output int at, output int en_seen);
        at      = -1;
        en_seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (set_en) en_seen++;
            if (res_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_clear", res_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_set_en"}, set_en, 0);
        check({tag, "_set_central"}, set_central, 0);
        check({tag, "_set_radius"}, set_radius, 0);
        check({tag, "_set_mode"}, set_mode, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_candidate"}, res_candidate, 0);
        check({tag, "_res_mode"}, res_mode, 0);
        check({tag, "_err"}, err, 0);
    endtask

    int t_push, t_en, t_res, en_cnt, rv_cnt;

    initial begin
        // Expected counts: r=0 -> 1, r=1 -> 5, r=2 -> 13, r>=3 -> 25.
        vecs[0] = '{24'h444444, 12'h333, 2'd0, 8'd25};
        vecs[1] = '{24'h000010, 12'h001, 2'd1, 8'd5};
        vecs[2] = '{24'hABCDEF, 12'h002, 2'd2, 8'd13};
        vecs[3] = '{24'h800001, 12'h000, 2'd3, 8'd1};
        vecs[4] = '{24'h123456, 12'hAB3, 2'd2, 8'd25};
        bp[0]   = '{24'h100000, 12'h000, 2'd0, 8'd1};
        bp[1]   = '{24'h200000, 12'h001, 2'd1, 8'd5};
        bp[2]   = '{24'h300000, 12'h002, 2'd2, 8'd13};
        bp[3]   = '{24'h400000, 12'h003, 2'd3, 8'd25};
        bp[4]   = '{24'hDEAD00, 12'h001, 2'd3, 8'd5};

        rst = 1'b0; cmd_valid = 1'b0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
        res_ready = 1'b0; eng_stall = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // set_valid outside WAIT must not produce a result
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("spur_res_valid", res_valid, 0);
        @(negedge clk);
        check("spur_res_valid2", res_valid, 0);

        for (int v = 0; v < 5; v++) begin
            push_cmd(vecs[v], t_push);
            wait_set_en(10, t_en);
            check("set_en_seen", t_en >= 0, 1);
            check("push_to_issue", t_en - t_push, 2);
            check("set_central", set_central, vecs[v].central);
            check("set_radius", set_radius, vecs[v].radius);
            check("set_mode", set_mode, vecs[v].mode);
            @(negedge clk);
            check("set_en_pulse", set_en, 0);
            wait_res(100, t_res, en_cnt);
            check("latency", t_res - t_en, 66);
            check("res_candidate", res_candidate, vecs[v].exp_cand);
            check("res_mode", res_mode, vecs[v].mode);
            check("no_set_en_in_wait", en_cnt, 0);
            check("set_mode_stable", set_mode, vecs[v].mode);
            check("set_radius_stable", set_radius, vecs[v].radius);
            check("err_clear", err, 0);
            take_result();
        end

        // Output backpressure while filling the FIFO
        push_cmd(vecs[1], t_push);
        wait_set_en(10, t_en);
        wait_res(100, t_res, en_cnt);
        check("bp_res_seen", t_res >= 0, 1);
        for (int i = 0; i < 20; i++) begin
            cmd_valid = (i < 5);
            if (i < 5) begin
                cmd_central = bp[i].central;
                cmd_radius  = bp[i].radius;
                cmd_mode    = bp[i].mode;
            end
            check("bp_cmd_ready", cmd_ready, (i < 4) ? 1 : 0);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_candidate", res_candidate, vecs[1].exp_cand);
            check("bp_res_mode", res_mode, vecs[1].mode);
            check("bp_set_en", set_en, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_release", res_valid, 0);
        check("bp_idle_set_en", set_en, 0);
        @(negedge clk);
        check("bp_next_issue", set_en, 1);
        check("bp_next_central", set_central, bp[0].central);
        for (int j = 0; j < 4; j++) begin
            wait_res(100, t_res, en_cnt);
            check("fifo_res_seen", t_res >= 0, 1);
            check("fifo_order_cand", res_candidate, bp[j].exp_cand);
            check("fifo_order_mode", res_mode, bp[j].mode);
            take_result();
        end
        wait_set_en(100, t_en);
        check("fifth_not_captured", t_en, -1);

        // Reset mid-WAIT with two commands queued
        push_cmd(vecs[3], t_push);
        wait_set_en(10, t_en);
        push_cmd(vecs[0], t_push);
        push_cmd(vecs[2], t_push);
        repeat (28) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ready_after", cmd_ready, 1);
        rv_cnt = 0;
        en_cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
            if (set_en) en_cnt++;
        end
        check("mid_no_result", rv_cnt, 0);
        check("mid_no_issue", en_cnt, 0);

        // Engine that never completes
        eng_stall = 1'b1;
        push_cmd(vecs[4], t_push);
        wait_set_en(10, t_en);
        check("tmo_issue_seen", t_en >= 0, 1);
`ifdef SET_DISP_TIMEOUT_EN
        wait_res(120, t_res, en_cnt);
        check("tmo_latency", t_res - t_en, 81);
        check("tmo_err", err, 1);
        check("tmo_candidate", res_candidate, 8'hFF);
        check("tmo_mode", res_mode, vecs[4].mode);
        take_result();
        check("tmo_err_sticky", err, 1);
`else
        rv_cnt = 0;
        en_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (res_valid) rv_cnt++;
            if (err) en_cnt++;
        end
        check("notmo_no_result", rv_cnt, 0);
        check("notmo_err_low", en_cnt, 0);
`endif
        eng_stall = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("final_err_cleared", err, 0);
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
